// File: rtl/int_square_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_square_gen_if
//  Description : Start/busy/done handshake and result bus of the iterative
//                integer squarer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface int_square_gen_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     n;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   square;
  logic [1:0]           state;

  // Requester side: issues start/operand, observes status and result
  modport master (
    output start,
    output n,
    input  busy,
    input  done,
    input  square,
    input  state
  );

  // Squarer side
  modport slave (
    input  start,
    input  n,
    output busy,
    output done,
    output square,
    output state
  );
endinterface
`default_nettype wire

// File: rtl/int_square_gen.sv
`default_nettype none
// ============================================================================
//  Module      : int_square_gen
//  Description : Iterative integer squarer. Computes n*n by accumulating the
//                first n odd numbers, one per clock, behind a start/busy/done
//                handshake. One operation in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_square_gen #(
  parameter int WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  int_square_gen_if.slave   sq
);

  localparam logic [1:0]       c_ST_IDLE = 2'b00;
  localparam logic [1:0]       c_ST_RUN  = 2'b01;
  localparam logic [1:0]       c_ST_DONE = 2'b10;
  localparam logic [WIDTH-1:0] c_ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   c_TWO_O   = {{(WIDTH-1){1'b0}}, 2'b10};
  localparam logic [WIDTH:0]   c_ONE_O   = {{WIDTH{1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [WIDTH-1:0]     r_n_reg;
  logic [WIDTH-1:0]     r_count;
  logic [WIDTH:0]       r_odd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_square;

  logic [WIDTH-1:0]     w_count_next;
  logic [2*WIDTH-1:0]   w_acc_sum;
  logic                 w_last_step;
  logic                 w_n_zero;
  logic                 w_busy;
  logic                 w_done;

  // Shared datapath terms: next accumulator value and the final-step detect
  assign w_count_next = r_count + c_ONE_W;
  assign w_acc_sum    = r_acc + {{(WIDTH-1){1'b0}}, r_odd};
  assign w_last_step  = (w_count_next == r_n_reg);
  assign w_n_zero     = (sq.n == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    w_state_next = c_ST_IDLE;
    case (r_state)
      c_ST_IDLE: begin
        if (sq.start) begin
          w_state_next = w_n_zero ? c_ST_DONE : c_ST_RUN;
        end else begin
          w_state_next = c_ST_IDLE;
        end
      end
      c_ST_RUN:  w_state_next = w_last_step ? c_ST_DONE : c_ST_RUN;
      c_ST_DONE: w_state_next = c_ST_IDLE;
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  // Status outputs decoded purely from the state register
  always_comb begin
    w_busy = (r_state != c_ST_IDLE);
    w_done = (r_state == c_ST_DONE);
  end

  // Odd-number accumulator: capture on accept, add one odd term per RUN edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_reg  <= '0;
      r_count  <= '0;
      r_odd    <= c_ONE_O;
      r_acc    <= '0;
      r_square <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (sq.start) begin
            r_n_reg <= sq.n;
            r_count <= '0;
            r_odd   <= c_ONE_O;
            r_acc   <= '0;
            if (w_n_zero) begin
              r_square <= '0;
            end
          end
        end
        c_ST_RUN: begin
          r_acc   <= w_acc_sum;
          r_odd   <= r_odd + c_TWO_O;
          r_count <= w_count_next;
          if (w_last_step) begin
            r_square <= w_acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sq.busy   = w_busy;
  assign sq.done   = w_done;
  assign sq.square = r_square;
  assign sq.state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_int_square_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_square_gen
//  Description : Self-checking bench for int_square_gen. Expected results come
//                from plain arithmetic (n*n, n RUN cycles before done).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_square_gen;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  int_square_gen_if #(.WIDTH(WIDTH)) bus ();

  int_square_gen #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sq    (bus)
  );

  always #5 clk = ~clk;

  // Count every done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete operation from IDLE; optional random start/n noise while RUN
  task automatic run_op(input int n_val, input bit noise);
    int cycles;
    bus.n     = n_val[WIDTH-1:0];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.n     = WIDTH'($urandom);
    cycles    = 0;
    while (bus.done !== 1'b1 && cycles < n_val + 4) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.n     = WIDTH'($urandom);
      end
      tick();
      cycles++;
    end
    bus.start = 1'b0;
    check("latency", cycles, n_val);
    check("square", 32'(bus.square), n_val * n_val);
    check("busy_in_done", 32'(bus.busy), 1);
    check("state_done", 32'(bus.state), 2);
    tick();
    check("state_after_done", 32'(bus.state), 0);
    check("done_after_done", 32'(bus.done), 0);
  endtask

  initial begin
    int cycles;
    int base;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.n     = '0;
    repeat (3) tick();
    check("reset_state", 32'(bus.state), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_square", 32'(bus.square), 0);
    reset = 1'b0;
    tick();

    // n = 0: DONE directly after the accepting edge
    check("idle_busy_n0", 32'(bus.busy), 0);
    run_op(0, 1'b0);
    check("busy_after_n0", 32'(bus.busy), 0);

    // n = 1
    run_op(1, 1'b0);

    // n = 12 and result hold in IDLE
    run_op(12, 1'b0);
    repeat (10) tick();
    check("hold_144", 32'(bus.square), 144);
    check("hold_idle", 32'(bus.state), 0);

    // n = 255 with ignored starts mid-RUN and during DONE
    bus.n     = 8'd255;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (100) tick();
    bus.n     = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cycles    = 101;
    while (bus.done !== 1'b1 && cycles < 300) begin
      tick();
      cycles++;
    end
    check("latency_255", cycles, 255);
    check("square_255", 32'(bus.square), 65025);
    bus.n     = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("done_start_ignored", 32'(bus.state), 0);
    check("square_255_kept", 32'(bus.square), 65025);
    tick();
    check("start_not_queued", 32'(bus.state), 0);
    check("not_queued_busy", 32'(bus.busy), 0);

    // Abort with reset mid-RUN
    base      = done_seen;
    bus.n     = 8'd200;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (50) tick();
    check("abort_running", 32'(bus.state), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", 32'(bus.state), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_square", 32'(bus.square), 0);
    check("abort_done", 32'(bus.done), 0);
    repeat (250) tick();
    check("abort_no_done", done_seen - base, 0);
    run_op(7, 1'b0);

    // Randomized operands, gaps and busy-time noise
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_op(int'($urandom_range(0, 255)), 1'b1);
    end

    // Back-to-back sweep of every operand
    base = done_seen;
    for (int k = 0; k < 256; k++) begin
      run_op(k, 1'b0);
    end
    check("sweep_done_count", done_seen - base, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_square_gen.md
Name: int_square_gen

Overview:
Iterative integer squarer. It is the inverse companion of the square-root finder: it computes n*n by summing the first n odd numbers (1+3+5+...), using the same odd-accumulate datapath style. It feeds square values to the square-root unit for round-trip checks, and serves as a small start/done coprocessor. One operation is in flight at a time; a start/busy/done handshake controls it.

Parameters:
WIDTH, 8, operand width in bits; result width is 2*WIDTH.

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
n  input  WIDTH  operand; captured on the edge that accepts start
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; square is valid while high
square  output  2*WIDTH  result; held until the next accepted start or reset
state  output  2  FSM state, for debug: 00 IDLE, 01 RUN, 10 DONE

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE, busy=0, done=0, square=0.
  - Internal registers: acc=0, odd=1, count=0, n_reg=0.
  - Reset overrides all other inputs on the same edge.
- Internal widths:
  - n_reg: WIDTH.
  - count: WIDTH.
  - odd: WIDTH+1 (maximum 2*(2^WIDTH-1)+1).
  - acc: 2*WIDTH.
  - All additions are unsigned and cannot overflow for any legal n.
- IDLE:
  - busy=0, done=0.
  - If start=1 on edge E0: n_reg<=n, acc<=0, odd<=1, count<=0.
  - Then, if n==0: square<=0 and state<=DONE.
  - Otherwise: state<=RUN.
- RUN, on each edge:
  - acc<=acc+odd, odd<=odd+2, count<=count+1.
  - If count+1==n_reg: square<=acc+odd and state<=DONE.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Next edge: state<=IDLE.
  - start asserted during DONE is ignored; it is not queued.
- Latency:
  - The accepting edge is E0; for n>=1 there are exactly n RUN edges.
  - done is visible in the cycle after edge E_n (after E0 for n=0).
  - The next start can be accepted on the edge after done, which is back-to-back throughput of n+2 cycles per op (2 for n=0).
- The n input may change freely after E0; only n_reg is used.
- start while busy (RUN or DONE) has no effect on n_reg, count or the result.
- square changes only on the DONE transition, on the accepting edge when n==0, or on reset. It is stable and readable in IDLE between operations.
- Reset asserted mid-RUN aborts the operation:
  - All outputs return to their reset values on that edge.
  - No done pulse is produced for the aborted operation.
- Illegal state encoding 11 returns to IDLE on the next edge with done=0.
- done and busy are registered outputs, i.e. decoded directly from state; there is no combinational path from start.

Test Plan:
- Reset then n=0, start pulse:
  - done pulses in the cycle after the accepting edge; square=0.
  - busy high for exactly 1 cycle (the DONE cycle).
- n=1, start: exactly 1 RUN cycle, then done with square=1.
- n=12, start: 12 RUN cycles; done pulse with square=144; square still 144 ten cycles later in IDLE.
- n=255, start:
  - done after 255 RUN cycles; square=65025 (0xFE01).
  - A second start with n=3, pulsed mid-RUN and again during DONE, is ignored; the result is still 65025.
- n=200, start; assert reset after 50 RUN cycles:
  - On that edge: state=00, busy=0, square=0.
  - No done pulse ever appears.
  - Then start with n=7 gives square=49.
- Back-to-back sweep: n=0..255 with start asserted on the first IDLE cycle after each done; every result equals n*n and done count equals 256.
